// File: rtl/ita_hwpe_job_dispatcher_if.sv
// ITA HWPE shared defaults and the peripheral control bus.
// Package: ITA_IO_REGS, ID_WIDTH. Interface: req/gnt/add/wen/be/data/id, r_data/r_valid/r_id.
package ita_hwpe_package;
  parameter int unsigned ITA_IO_REGS = 4;
  parameter int unsigned ID_WIDTH    = 8;
endpackage

interface hwpe_ctrl_intf_periph #(
  parameter int unsigned ID_WIDTH = ita_hwpe_package::ID_WIDTH
) ();
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic [31:0]         r_data;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );
endinterface

// File: rtl/ita_hwpe_job_dispatcher.sv
// ITA HWPE job dispatcher: acquire context, write job regs, trigger, await done.
// Ports: clk_i, rst_i (sync, active-high), job_valid_i/job_ready_o/job_regs_i,
//   done_valid_o/done_id_o, busy_o, evt_i, periph (hwpe_ctrl_intf_periph master).
// Build option: define ITA_DISPATCH_POLL_EN to poll the status register
//   (BASE_ADDR+0x0C) for completion instead of waiting for evt_i.
module ita_hwpe_job_dispatcher #(
  parameter int unsigned N_REGS    = ita_hwpe_package::ITA_IO_REGS,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned ID_WIDTH  = ita_hwpe_package::ID_WIDTH,
  parameter int unsigned BACKOFF   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [N_REGS-1:0][31:0] job_regs_i,
  output logic                   done_valid_o,
  output logic [7:0]             done_id_o,
  output logic                   busy_o,
  input  logic                   evt_i,
  hwpe_ctrl_intf_periph.master   periph
);

  localparam int unsigned IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned CW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REGS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BACKOFF - 1);
  localparam logic [31:0] ADDR_TRIG = BASE_ADDR;
  localparam logic [31:0] ADDR_ACQ  = BASE_ADDR + 32'h04;
  localparam logic [31:0] ADDR_STAT = BASE_ADDR + 32'h0C;
  localparam logic [31:0] ADDR_REGS = BASE_ADDR + 32'h20;

  typedef enum logic [3:0] {
    IDLE,
    ACQ_REQ,
    ACQ_RSP,
    BACK_OFF,
    WR_REGS,
    TRIGGER,
    WAIT_DONE,
    POLL_RSP,
    POLL_GAP
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [7:0]              id_q, id_d;
  logic [N_REGS-1:0][31:0] buf_q, buf_d;
  logic                    done_q, done_d;
  logic [7:0]              done_id_q, done_id_d;

  logic                    req_c;
  logic                    wen_c;
  logic [31:0]             add_c;
  logic [31:0]             data_c;
  logic [3:0]              be_c;
  logic [ID_WIDTH-1:0]     id_zero;
  logic                    rsp_ok;

  // Only our own (id 0) read responses are consumed.
  assign id_zero = '0;
  assign rsp_ok  = periph.r_valid && (periph.r_id == id_zero);

  assign job_ready_o  = (state_q == IDLE) && !rst_i;
  assign busy_o       = (state_q != IDLE);
  assign done_valid_o = done_q;
  assign done_id_o    = done_id_q;

  assign periph.req  = req_c;
  assign periph.wen  = wen_c;
  assign periph.add  = add_c;
  assign periph.data = data_c;
  assign periph.be   = be_c;
  assign periph.id   = id_zero;

  logic unused_bits;
`ifdef ITA_DISPATCH_POLL_EN
  assign unused_bits = ^{periph.r_data[30:8], evt_i};
`else
  assign unused_bits = ^{periph.r_data[30:8]};
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    buf_d     = buf_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    req_c     = 1'b0;
    wen_c     = 1'b1;
    add_c     = '0;
    data_c    = '0;
    be_c      = '0;

    unique case (state_q)
      IDLE: begin
        if (job_valid_i && job_ready_o) begin
          buf_d   = job_regs_i;
          state_d = ACQ_REQ;
        end
      end

      ACQ_REQ: begin
        req_c = 1'b1;
        add_c = ADDR_ACQ;
        be_c  = 4'hF;
        if (periph.gnt) state_d = ACQ_RSP;
      end

      ACQ_RSP: begin
        if (rsp_ok) begin
          // bit 31 set: no free context, retry later
          if (periph.r_data[31]) begin
            cnt_d   = '0;
            state_d = (BACKOFF == 0) ? ACQ_REQ : BACK_OFF;
          end else begin
            id_d    = periph.r_data[7:0];
            idx_d   = '0;
            state_d = WR_REGS;
          end
        end
      end

      BACK_OFF: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ACQ_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WR_REGS: begin
        req_c  = 1'b1;
        wen_c  = 1'b0;
        be_c   = 4'hF;
        add_c  = ADDR_REGS + (32'(idx_q) << 2);
        data_c = buf_q[idx_q];
        if (periph.gnt) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = TRIGGER;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      TRIGGER: begin
        req_c = 1'b1;
        wen_c = 1'b0;
        be_c  = 4'hF;
        add_c = ADDR_TRIG;
        if (periph.gnt) state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
`ifdef ITA_DISPATCH_POLL_EN
        req_c = 1'b1;
        add_c = ADDR_STAT;
        be_c  = 4'hF;
        if (periph.gnt) state_d = POLL_RSP;
`else
        if (evt_i) begin
          done_d    = 1'b1;
          done_id_d = id_q;
          state_d   = IDLE;
        end
`endif
      end

      POLL_RSP: begin
`ifdef ITA_DISPATCH_POLL_EN
        if (rsp_ok) begin
          // status bit 0 set: accelerator still busy
          if (periph.r_data[0]) begin
            cnt_d   = '0;
            state_d = (BACKOFF == 0) ? WAIT_DONE : POLL_GAP;
          end else begin
            done_d    = 1'b1;
            done_id_d = id_q;
            state_d   = IDLE;
          end
        end
`else
        state_d = IDLE;
`endif
      end

      POLL_GAP: begin
`ifdef ITA_DISPATCH_POLL_EN
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      buf_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      buf_q     <= buf_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

endmodule
